fifo_tx_serializer: RTL

- Read-side consumer of the tx FIFO in the fifo controller path.
- Drains 32-bit words from the FIFO read port in whole blocks and splits each word into 4-bit nibbles for the card data-bus driver.
- Nibbles leave through a valid/ready handshake.
- Lives entirely in the FIFO read-clock domain and drives the FIFO's read_enable directly.

---
 rtl/fifo_tx_serializer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fifo_tx_serializer.sv
// fifo_tx_serializer: read-side consumer of the tx FIFO. Pops whole blocks of
// DATA_WIDTH-bit words and emits each word as DATA_WIDTH/BUS_WIDTH nibbles over
// a valid/ready handshake toward the card data-bus driver.
// Optional build macro: TX_SERIALIZER_LSB_FIRST_EN (when defined, nibbles leave
// least-significant first; timing and handshakes are unchanged).
module fifo_tx_serializer #(
  parameter int DATA_WIDTH  = 32,
  parameter int BUS_WIDTH   = 4,
  parameter int BLOCK_WORDS = 128,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   read_clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] block_count,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  q,
  output logic                   read_enable,
  output logic [BUS_WIDTH-1:0]   serial_data,
  output logic                   serial_valid,
  input  logic                   serial_ready,
  output logic                   busy,
  output logic                   stalled,
  output logic                   block_done,
  output logic                   xfer_done,
  output logic [COUNT_WIDTH-1:0] blocks_left
);

  localparam int NIBBLES = DATA_WIDTH / BUS_WIDTH;
  localparam int NC_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int WC_W    = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [NC_W-1:0] NC_LAST = NC_W'(NIBBLES - 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(BLOCK_WORDS - 1);
  localparam logic [COUNT_WIDTH-1:0] BLK_ONE = COUNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SHIFT,
    S_BLOCK_END
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [DATA_WIDTH-1:0]  r_shreg;
  logic [NC_W-1:0]        r_nib_cnt;
  logic [WC_W-1:0]        r_word_cnt;
  logic [COUNT_WIDTH-1:0] r_blocks_left;

  logic w_start_ok;
  logic w_accept;
  logic w_last_nib;
  logic w_last_word;
  logic w_last_block;

  assign w_start_ok   = start && (block_count != '0);
  assign w_accept     = (r_state == S_SHIFT) && serial_ready;
  assign w_last_nib   = w_accept && (r_nib_cnt == NC_LAST);
  assign w_last_word  = (r_word_cnt == WC_LAST);
  assign w_last_block = (r_blocks_left == BLK_ONE);

  assign blocks_left = r_blocks_left;

`ifdef TX_SERIALIZER_LSB_FIRST_EN
  assign serial_data = r_shreg[BUS_WIDTH-1:0];
`else
  assign serial_data = r_shreg[DATA_WIDTH-1 -: BUS_WIDTH];
`endif

  // State register.
  always_ff @(posedge read_clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and per-state output strobes; read_enable is only ever
  // raised in FETCH so the FIFO sees exactly one pop per word.
  always_comb begin
    w_next       = r_state;
    read_enable  = 1'b0;
    stalled      = 1'b0;
    serial_valid = 1'b0;
    block_done   = 1'b0;
    xfer_done    = 1'b0;
    busy         = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_next = S_FETCH;
        end
      end
      S_FETCH: begin
        read_enable = !fifo_empty;
        stalled     = fifo_empty;
        if (!fifo_empty) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        w_next = S_SHIFT;
      end
      S_SHIFT: begin
        serial_valid = 1'b1;
        if (w_last_nib) begin
          w_next = w_last_word ? S_BLOCK_END : S_FETCH;
        end
      end
      S_BLOCK_END: begin
        block_done = 1'b1;
        if (w_last_block) begin
          xfer_done = 1'b1;
          w_next    = S_IDLE;
        end else begin
          w_next = S_FETCH;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Shift register and nibble counter: load on LOAD, advance on each accepted beat.
  always_ff @(posedge read_clock) begin
    if (reset) begin
      r_shreg   <= '0;
      r_nib_cnt <= '0;
    end else if (r_state == S_LOAD) begin
      r_shreg   <= q;
      r_nib_cnt <= '0;
    end else if (w_accept) begin
`ifdef TX_SERIALIZER_LSB_FIRST_EN
      r_shreg <= r_shreg >> BUS_WIDTH;
`else
      r_shreg <= r_shreg << BUS_WIDTH;
`endif
      r_nib_cnt <= (r_nib_cnt == NC_LAST) ? '0 : r_nib_cnt + NC_W'(1);
    end
  end

  // Word-in-block counter; wraps to zero only when the block's last word finishes.
  always_ff @(posedge read_clock) begin
    if (reset) begin
      r_word_cnt <= '0;
    end else if ((r_state == S_IDLE) && w_start_ok) begin
      r_word_cnt <= '0;
    end else if (w_last_nib) begin
      r_word_cnt <= w_last_word ? '0 : r_word_cnt + WC_W'(1);
    end
  end

  // Remaining-block count: latched on an accepted start, decremented at each block end.
  always_ff @(posedge read_clock) begin
    if (reset) begin
      r_blocks_left <= '0;
    end else if ((r_state == S_IDLE) && w_start_ok) begin
      r_blocks_left <= block_count;
    end else if ((r_state == S_BLOCK_END) && (r_blocks_left != '0)) begin
      r_blocks_left <= r_blocks_left - BLK_ONE;
    end
  end

endmodule
